// File: rtl/sensor_stream_sim.sv
// Purpose: multi-channel emulated sensor; each channel emits a sample per period and holds it under a ready/ack handshake.
// Latency: sample and ready appear on the tick edge; extracted_data follows sel or the selected slice by one cycle.
// Backpressure: none; an unacknowledged sample is overwritten by the next one and flagged as overrun.
module sensor_stream_sim #(
    parameter int          CHANNELS    = 8,
    parameter int          SAMPLE_W    = 16,
    parameter int          BASE_PERIOD = 100,
    parameter int          PERIOD_STEP = 10,
    parameter int          MODE        = 0,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                                           clock,
    input  logic                                           resetn,
    input  logic                                           enable,
    input  logic [CHANNELS-1:0]                            ack,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel,
    output logic [CHANNELS-1:0]                            ready,
    output logic [CHANNELS-1:0]                            overrun,
    output logic [CHANNELS*SAMPLE_W-1:0]                   data_out,
    output logic [SAMPLE_W-1:0]                            extracted_data
);

    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    // Longest period belongs to the highest channel; counters only ever hold period-1.
    localparam int PERIOD_MAX = BASE_PERIOD + (CHANNELS - 1) * PERIOD_STEP;
    localparam int CNT_W      = (PERIOD_MAX > 2) ? $clog2(PERIOD_MAX) : 1;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            localparam int                    PERIOD   = BASE_PERIOD + gi * PERIOD_STEP;
            localparam logic [CNT_W-1:0]      RELOAD   = CNT_W'(PERIOD - 1);
            localparam logic [15:0]           SEED_MIX = SEED ^ 16'(gi);
            // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
            localparam logic [15:0]           CH_SEED  = (SEED_MIX == 16'h0000) ? 16'h0001 : SEED_MIX;
            localparam logic [SAMPLE_W-1:0]   GEN_INIT = (MODE == 1) ? SAMPLE_W'(CH_SEED)
                                                                     : {SAMPLE_W{1'b0}};

            logic [CNT_W-1:0]    cnt_q;
            logic [SAMPLE_W-1:0] gen_q;
            logic [SAMPLE_W-1:0] gen_nxt;
            logic [SAMPLE_W-1:0] smp_q;
            logic                rdy_q;
            logic                ovr_q;
            logic                tick;
            logic                take;

            // A tick fires on the enabled edge where the down-counter has reached zero.
            assign tick = enable && (cnt_q == {CNT_W{1'b0}});
            // An ack only counts while a sample is actually being held.
            assign take = ack[gi] && rdy_q;

            if (MODE == 1) begin : g_lfsr
                // Galois LFSR step with feedback mask 0xB400.
                assign gen_nxt = (gen_q >> 1) ^ (gen_q[0] ? SAMPLE_W'(16'hB400) : {SAMPLE_W{1'b0}});
            end else begin : g_count
                // Free-running counter, wraps naturally at the sample width.
                assign gen_nxt = gen_q + SAMPLE_W'(1);
            end

            // Period counter: count down while enabled, reload on the tick edge.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    cnt_q <= RELOAD;
                end else if (enable) begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        cnt_q <= RELOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
            end

            // Generator state advances one step per tick.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    gen_q <= GEN_INIT;
                end else if (tick) begin
                    gen_q <= gen_nxt;
                end
            end

            // Held sample takes the freshly generated value on each tick.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    smp_q <= {SAMPLE_W{1'b0}};
                end else if (tick) begin
                    smp_q <= gen_nxt;
                end
            end

            // Handshake flags: a tick always leaves ready set; an overrun is only
            // recorded when the previous sample was neither consumed nor acked.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    rdy_q <= 1'b0;
                    ovr_q <= 1'b0;
                end else begin
                    if (tick) begin
                        rdy_q <= 1'b1;
                    end else if (take) begin
                        rdy_q <= 1'b0;
                    end

                    if (take) begin
                        ovr_q <= 1'b0;
                    end else if (tick && rdy_q) begin
                        ovr_q <= 1'b1;
                    end
                end
            end

            assign ready[gi]                           = rdy_q;
            assign overrun[gi]                         = ovr_q;
            assign data_out[gi*SAMPLE_W +: SAMPLE_W]   = smp_q;
        end
    endgenerate

    logic [SAMPLE_W-1:0] ext_nxt;

    // Select the requested slice; an index beyond the channel count yields zero.
    always_comb begin
        ext_nxt = {SAMPLE_W{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) begin
                ext_nxt = data_out[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Register the selected slice every edge so the narrow output is glitch-free.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            extracted_data <= {SAMPLE_W{1'b0}};
        end else begin
            extracted_data <= ext_nxt;
        end
    end

endmodule
